// File: rtl/svpwm_gen_if.sv
// -----------------------------------------------------------------------------
// svpwm_gen_if
//   Bundles the stream signals of svpwm_gen.
//
//   Input stream (vector in):
//     s_axis_tdata   {v_beta, v_alpha}, both signed Q1.15
//     s_axis_tvalid  input vector valid
//     s_axis_tready  block can accept a vector
//   Output stream (duties out, no back-pressure):
//     m_axis_tdata   {duty_c, duty_b, duty_a}, unsigned compare words
//     m_axis_tvalid  one-cycle strobe per new duty triple
//   Debug:
//     dbg_state      current FSM state encoding
//
//   Modports: slave = the svpwm_gen block, master = the upstream driver and
//   the downstream consumer.
// -----------------------------------------------------------------------------
interface svpwm_gen_if #(
   parameter int DATA_WIDTH = 16
);
   logic [2*DATA_WIDTH-1:0] s_axis_tdata;
   logic                    s_axis_tvalid;
   logic                    s_axis_tready;
   logic [3*DATA_WIDTH-1:0] m_axis_tdata;
   logic                    m_axis_tvalid;
   logic [3:0]              dbg_state;

   modport slave (
      input  s_axis_tdata, s_axis_tvalid,
      output s_axis_tready, m_axis_tdata, m_axis_tvalid, dbg_state
   );

   modport master (
      output s_axis_tdata, s_axis_tvalid,
      input  s_axis_tready, m_axis_tdata, m_axis_tvalid, dbg_state
   );
endinterface

// File: rtl/svpwm_gen.sv
// -----------------------------------------------------------------------------
// svpwm_gen
//   Space-vector modulation stage: converts a normalised alpha/beta voltage
//   vector (signed Q1.15) into three unsigned PWM compare words in the range
//   0..PWM_RELOAD-1. Zero-sequence is injected with the min-max method, which
//   is equivalent to classic SVPWM without a sector table.
//
//   Ports:
//     clk   single clock
//     rst   synchronous, active-high reset
//     bus   svpwm_gen_if.slave (s_axis vector in, m_axis duties out, dbg_state)
//
//   Handshake: a vector is transferred on a rising edge where s_axis_tvalid
//   and s_axis_tready are both high; tready is high only in IDLE (and low
//   while rst is high). m_axis_tvalid is a one-cycle strobe with no
//   back-pressure; m_axis_tdata holds its value between strobes.
//
//   Compile-time option:
//     SVPWM_ZERO_SEQ_EN  defined -> min-max offset injection (SVPWM)
//                        undefined -> offset forced to 0 (sinusoidal PWM);
//                        MINMAX/OFF are still traversed so timing is equal.
//
//   Latency: accept at edge N -> m_axis_tvalid high after edge N+8.
// -----------------------------------------------------------------------------
module svpwm_gen #(
   parameter int DATA_WIDTH = 16,
   parameter int PWM_RELOAD = 5000
) (
   input logic        clk,
   input logic        rst,
   svpwm_gen_if.slave bus
);
   localparam int W  = DATA_WIDTH;
   localparam int VW = W + 2;                    // phase voltage width
   localparam int SW = W + 3;                    // offset / sum headroom
   localparam int RW = $clog2(PWM_RELOAD + 1);   // reload constant width

   localparam logic [RW-1:0]        RELOAD_V   = RW'(PWM_RELOAD);
   // sqrt(3)/2 in Q1.15
   localparam logic signed [W-1:0]  SQRT3_HALF = W'(28378);
   localparam logic signed [SW-1:0] SAT_HI     = SW'((2 ** (W - 1)) - 1);
   localparam logic signed [SW-1:0] SAT_LO     = SW'(-(2 ** (W - 1)));

   typedef enum logic [3:0] {
      IDLE, INV, SUM, MINMAX, OFF, MUL0, MUL1, MUL2, OUT
   } state_t;

   state_t     state, state_nxt;
   logic       s_ready;
   logic [1:0] mul_sel;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      s_ready   = 1'b0;
      mul_sel   = 2'd0;
      case (state)
         IDLE: begin
            s_ready = 1'b1;
            if (bus.s_axis_tvalid) state_nxt = INV;
         end
         INV:    state_nxt = SUM;
         SUM:    state_nxt = MINMAX;
         MINMAX: state_nxt = OFF;
         OFF:    state_nxt = MUL0;
         MUL0: begin mul_sel = 2'd0; state_nxt = MUL1; end
         MUL1: begin mul_sel = 2'd1; state_nxt = MUL2; end
         MUL2: begin mul_sel = 2'd2; state_nxt = OUT;  end
         OUT:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.s_axis_tready = s_ready & ~rst;
   assign bus.dbg_state     = state;

   // ----------------------------------------------------------- datapath
   logic signed [W-1:0]   alpha_r, beta_r;
   logic signed [W:0]     p_hi;          // floor(beta*sqrt3/2 / 2^15)
   logic signed [VW-1:0]  va, vb, vc, vmax, vmin;
   logic signed [W-1:0]   va_s, vb_s, vc_s;
   logic [W-1:0]          duty_a, duty_b, duty_c;

   logic signed [2*W-1:0] p_full;
   logic signed [VW-1:0]  alpha_x, half_neg, p_x;
   logic signed [VW-1:0]  mx_ab, mn_ab, mx_abc, mn_abc;
   logic signed [SW-1:0]  offset, va_o, vb_o, vc_o;
   logic signed [W-1:0]   mul_in;
   logic [W-1:0]          biased;
   logic [W+RW-1:0]       prod;
   logic [W-1:0]          duty_new;

   assign p_full   = beta_r * SQRT3_HALF;
   assign alpha_x  = {{2{alpha_r[W-1]}}, alpha_r};
   assign half_neg = (-alpha_x) >>> 1;
   assign p_x      = {p_hi[W], p_hi};

   always_comb begin
      mx_ab  = (va > vb) ? va : vb;
      mn_ab  = (va < vb) ? va : vb;
      mx_abc = (mx_ab > vc) ? mx_ab : vc;
      mn_abc = (mn_ab < vc) ? mn_ab : vc;
   end

`ifdef SVPWM_ZERO_SEQ_EN
   logic signed [SW-1:0] sum_mm;
   assign sum_mm = {vmax[VW-1], vmax} + {vmin[VW-1], vmin};
   assign offset = -(sum_mm >>> 1);
`else
   assign offset = '0;
`endif

   assign va_o = {va[VW-1], va} + offset;
   assign vb_o = {vb[VW-1], vb} + offset;
   assign vc_o = {vc[VW-1], vc} + offset;

   function automatic logic signed [W-1:0] sat(input logic signed [SW-1:0] x);
      if (x > SAT_HI)      sat = SAT_HI[W-1:0];
      else if (x < SAT_LO) sat = SAT_LO[W-1:0];
      else                 sat = x[W-1:0];
   endfunction

   // Shared multiplier; adding 2^(W-1) to a signed word is an MSB flip.
   always_comb begin
      case (mul_sel)
         2'd1:    mul_in = vb_s;
         2'd2:    mul_in = vc_s;
         default: mul_in = va_s;
      endcase
   end

   assign biased   = {~mul_in[W-1], mul_in[W-2:0]};
   assign prod     = biased * RELOAD_V;
   assign duty_new = {{(W-RW){1'b0}}, prod[W+RW-1:W]};

   // Low product bits are dropped by the fixed-point scaling.
   logic unused_bits;
`ifdef SVPWM_ZERO_SEQ_EN
   assign unused_bits = ^{p_full[W-2:0], prod[W-1:0]};
`else
   assign unused_bits = ^{p_full[W-2:0], prod[W-1:0], vmax, vmin};
`endif

   always_ff @(posedge clk) begin
      case (state)
         IDLE: if (bus.s_axis_tvalid) begin
            alpha_r <= bus.s_axis_tdata[W-1:0];
            beta_r  <= bus.s_axis_tdata[2*W-1:W];
         end
         INV: p_hi <= p_full[2*W-1:W-1];
         SUM: begin
            va <= alpha_x;
            vb <= half_neg + p_x;
            vc <= half_neg - p_x;
         end
         MINMAX: begin
            vmax <= mx_abc;
            vmin <= mn_abc;
         end
         OFF: begin
            va_s <= sat(va_o);
            vb_s <= sat(vb_o);
            vc_s <= sat(vc_o);
         end
         MUL0: duty_a <= duty_new;
         MUL1: duty_b <= duty_new;
         MUL2: duty_c <= duty_new;
         default: ;
      endcase
   end

   // Output register: all three duties update together on leaving OUT.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.m_axis_tdata  <= '0;
         bus.m_axis_tvalid <= 1'b0;
      end else begin
         bus.m_axis_tvalid <= (state == OUT);
         if (state == OUT) bus.m_axis_tdata <= {duty_c, duty_b, duty_a};
      end
   end
endmodule

// File: tb/tb_svpwm_gen.sv
module tb_svpwm_gen;
   localparam int W = 16;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;

   // ------------------------------------------------ clock / reset block
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   svpwm_gen_if #(.DATA_WIDTH(W)) bus ();

   svpwm_gen #(.DATA_WIDTH(W), .PWM_RELOAD(5000)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // ----------------------------------------------------- vector table
   typedef struct {
      logic [15:0] alpha;
      logic [15:0] beta;
      logic [47:0] exp;
   } vec_t;

   vec_t tab[7];

   function automatic vec_t mk(input int a, input int b, input int da, input int db, input int dc);
      vec_t v;
      v.alpha = 16'(a);
      v.beta  = 16'(b);
      v.exp   = {16'(dc), 16'(db), 16'(da)};
      return v;
   endfunction

   // ------------------------------------------------------- scoreboard
   logic [47:0] exp_q[$];
   int          exp_cyc_q[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h (%0d) expected 0x%0h (%0d) at cycle %0d",
                  tag, got, got, exp, exp, cyc);
      end
   endtask

   logic        prev_v = 1'b0;
   logic [47:0] last_d = '0;

   always @(negedge clk) begin
      if (bus.m_axis_tvalid) begin
         check("pulse_width", 64'(prev_v), 64'd0);
         if (exp_q.size() == 0) begin
            check("spurious_out", 64'd1, 64'd0);
         end else begin
            check("duty", 64'(bus.m_axis_tdata), 64'(exp_q.pop_front()));
            check("latency", 64'(cyc), 64'(exp_cyc_q.pop_front()));
         end
         last_d <= bus.m_axis_tdata;
      end else if (prev_v && !rst) begin
         check("hold", 64'(bus.m_axis_tdata), 64'(last_d));
      end
      prev_v <= bus.m_axis_tvalid;
   end

   // ---------------------------------------------------------- drivers
   task automatic send_vec(input int idx, input bit expect_out, output int acc);
      int n;
      n = 0;
      @(negedge clk);
      bus.s_axis_tdata  = {tab[idx].beta, tab[idx].alpha};
      bus.s_axis_tvalid = 1'b1;
      while (!bus.s_axis_tready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) begin
         check("ready_timeout", 64'd0, 64'd1);
         bus.s_axis_tvalid = 1'b0;
         acc = -1;
         return;
      end
      @(posedge clk);
      #1;
      acc = cyc;
      bus.s_axis_tvalid = 1'b0;
      if (expect_out) begin
         exp_q.push_back(tab[idx].exp);
         exp_cyc_q.push_back(acc + 8);
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         check("drain_timeout", 64'(exp_q.size()), 64'd0);
         exp_q.delete();
         exp_cyc_q.delete();
      end
      @(negedge clk);
   endtask

   // ------------------------------------------------------------ main
   initial begin
      int acc;
      tab[0] = mk(0, 0, 2500, 2500, 2500);
      tab[3] = mk(0, 16384, 2500, 3582, 1417);
      tab[5] = mk(1, 0, 2500, 2499, 2499);
`ifdef SVPWM_ZERO_SEQ_EN
      tab[1] = mk(16384, 0, 3437, 1562, 1562);
      tab[2] = mk(-32768, -32768, 0, 1127, 4999);
      tab[4] = mk(-16384, 0, 1562, 3437, 3437);
      tab[6] = mk(32767, 32767, 4999, 3872, 0);
`else
      tab[1] = mk(16384, 0, 3750, 1875, 1875);
      tab[2] = mk(-32768, -32768, 0, 1584, 4999);
      tab[4] = mk(-16384, 0, 1250, 3125, 3125);
      tab[6] = mk(32767, 32767, 4999, 3414, 0);
`endif

      rst = 1'b1;
      bus.s_axis_tvalid = 1'b0;
      bus.s_axis_tdata  = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_tdata",  64'(bus.m_axis_tdata),  64'd0);
      check("rst_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
      check("rst_tready", 64'(bus.s_axis_tready), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("ready_after_rst", 64'(bus.s_axis_tready), 64'd1);

      // Directed vectors one at a time
      for (int i = 0; i < 7; i++) begin
         send_vec(i, 1'b1, acc);
         drain();
      end

      // tvalid held high with new data every cycle
      for (int k = 0; k < 27; k++) begin
         bus.s_axis_tdata  = {tab[k % 7].beta, tab[k % 7].alpha};
         bus.s_axis_tvalid = 1'b1;
         check("stream_ready", 64'(bus.s_axis_tready), 64'((k % 9) == 0));
         if ((k % 9) == 0) begin
            exp_q.push_back(tab[k % 7].exp);
            exp_cyc_q.push_back(cyc + 1 + 8);
         end
         @(negedge clk);
      end
      bus.s_axis_tvalid = 1'b0;
      drain();

      // Reset while in MUL1 aborts the computation
      send_vec(1, 1'b0, acc);
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid_tready", 64'(bus.s_axis_tready), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("abort_tdata",  64'(bus.m_axis_tdata),  64'd0);
      check("abort_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
      check("abort_tready", 64'(bus.s_axis_tready), 64'd1);
      repeat (12) @(negedge clk);
      check("abort_tdata_late", 64'(bus.m_axis_tdata), 64'd0);
      send_vec(2, 1'b1, acc);
      drain();
      send_vec(6, 1'b1, acc);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end
endmodule
